ysyx_23060096_wb_unit: RTL
==========================

// Module: ysyx_23060096_wb_unit
// PURPOSE
//  Writeback stage directly upstream of the register file: accepts completed results from the EXU
//  (ALU/CSR) and LSU (load data), aligns/extends load data, arbitrates the single RF write port and
//  drives a registered write (waddr/wdata/w_en). Holds a pending-write scoreboard the IDU queries
//  for RAW stalls, and counts retired instructions for difftest.
// PARAMETERS
//  XLEN    32  datapath width
//  RA_W    5   register address width (2**RA_W registers)
//  CNT_W   64  retire counter width
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       synchronous reset, active-high
//  iss_valid     in   1       IDU issues an instr that will write rd
//  iss_rd        in   RA_W    destination of issued instr
//  rs1, rs2      in   RA_W    IDU source query
//  rs1_busy      out  1       rs1 has pending write (combinational from scoreboard)
//  rs2_busy      out  1       rs2 has pending write
//  exu_valid     in   1       EXU result valid
//  exu_ready     out  1       EXU result accepted this cycle when valid&ready
//  exu_rd        in   RA_W    EXU destination
//  exu_wen       in   1       0 = retire without RF write (branch/store)
//  exu_data      in   XLEN    EXU result
//  lsu_valid     in   1       load response valid
//  lsu_ready     out  1       load response accepted when valid&ready
//  lsu_rd        in   RA_W    load destination
//  lsu_funct3    in   3       LB=000 LH=001 LW=010 LBU=100 LHU=101
//  lsu_addr_lo   in   2       byte offset of load address
//  lsu_rdata     in   XLEN    raw aligned memory word
//  w_en          out  1       RF write enable (registered)
//  waddr         out  RA_W    RF write address (registered)
//  wdata         out  XLEN    RF write data (registered)
//  misalign_err  out  1       1-cycle pulse: misaligned or illegal-funct3 load dropped
//  instret       out  CNT_W   retired-instruction count
// BEHAVIOUR
//  - Reset: w_en=0, waddr=0, wdata=0, misalign_err=0, instret=0, scoreboard all clear. Reset wins
//    over every concurrent event; in-flight handshakes that cycle are discarded, ready outputs 0.
//  - Arbitration: fixed priority LSU > EXU. lsu_ready=~rst; exu_ready=~rst & ~lsu_valid.
//    At most one result accepted per cycle. No buffering beyond the output register.
//  - Latency: accepted result appears on w_en/waddr/wdata exactly 1 cycle later, pulse of 1 cycle.
//    No acceptance -> w_en=0 next cycle (waddr/wdata hold previous value).
//  - x0: result with rd=0 retires (instret+1) but w_en=0; iss_rd=0 never sets busy; rs*=0 never busy.
//  - Load extension: byte = rdata[8*lo+:8], half = rdata[16*lo[1]+:16]; LB/LH sign-extend,
//    LBU/LHU zero-extend, LW whole word. LH/LHU with lo[0]=1, LW with lo!=0, or funct3 not in set
//    -> accepted, no write, no retire, misalign_err=1 next cycle, busy[lsu_rd] cleared.
//  - EXU exu_wen=0: retire only, no write, scoreboard untouched.
//  - Scoreboard: busy[iss_rd] set on iss_valid; busy[rd] cleared when that result is accepted.
//    Same-cycle set and clear of the same rd: set wins (newer writer pending). busy visible to
//    rs*_busy the cycle after set; clear is visible the cycle after acceptance (write lands same edge).
//  - instret: +1 per retiring acceptance, wraps modulo 2**CNT_W.
// STRUCTURE
//  - Shared package ysyx_23060096_pkg: XLEN, RA_W, funct3 load encodings (LB..LHU).
//  - One sub-module: ysyx_23060096_load_align (combinational funct3/addr_lo/rdata -> data, err).
//  - Scoreboard, arbiter, output register, counter live in this module.
// TESTING
//  - Reset mid-stream: rst=1 with exu_valid, rd=5 -> next cycle w_en=0, instret=0, all busy=0.
//  - EXU only: rd=3, data=0xDEADBEEF -> next cycle w_en=1 waddr=3 wdata=0xDEADBEEF, instret=1.
//  - Contention: exu_valid & lsu_valid same cycle -> exu_ready=0, LSU written first, EXU next cycle.
//  - Loads: rdata=0x80FF7F01: LB lo=3 -> 0xFFFFFF80; LBU lo=1 -> 0x7F; LH lo=2 -> 0xFFFF80FF;
//    LW lo=1 -> w_en=0, misalign_err=1, instret unchanged.
//  - Scoreboard: issue rd=7 -> rs1=7 busy next cycle; accept rd=7 with iss_valid rd=7 same cycle
//    -> stays busy; rd=0 result -> w_en=0, instret+1.
//  - Counter wrap: preset CNT_W=4, 16 retirements -> instret returns to 0.

Source files
------------

// File: rtl/ysyx_23060096_pkg.sv
// Shared constants and types for the writeback stage: datapath widths, load funct3 encodings
// and the selected-result record passed from the arbiter to the output register.
package ysyx_23060096_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;
    localparam int unsigned NUM_REGS = 1 << RA_W;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One accepted result after arbitration; err marks a dropped load.
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
        logic            wen;
        logic            err;
    } wb_res_t;

    function automatic logic sign_of_byte(input logic [7:0] b, input logic sext);
        return sext & b[7];
    endfunction

endpackage

// File: rtl/ysyx_23060096_load_align.sv
// Combinational load formatter: picks the addressed byte/half from the memory word, extends it,
// and flags misaligned accesses or unknown funct3 encodings.
module ysyx_23060096_load_align
    import ysyx_23060096_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        unique case (funct3_i)
            F3_LB: begin
                data_o = {{(XLEN-8){sign_of_byte(byte_v, 1'b1)}}, byte_v};
            end
            F3_LBU: begin
                data_o = {{(XLEN-8){1'b0}}, byte_v};
            end
            F3_LH: begin
                data_o = {{(XLEN-16){half_v[15]}}, half_v};
                err_o  = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o = {{(XLEN-16){1'b0}}, half_v};
                err_o  = addr_lo_i[0];
            end
            F3_LW: begin
                data_o = rdata_i;
                err_o  = (addr_lo_i != 2'b00);
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060096_wb_unit.sv
// Writeback stage: arbitrates LSU/EXU results onto the single registered RF write port, tracks
// pending destinations for the IDU's RAW checks and counts retired instructions.
module ysyx_23060096_wb_unit
    import ysyx_23060096_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [RA_W-1:0]  iss_rd,
    input  logic [RA_W-1:0]  rs1,
    input  logic [RA_W-1:0]  rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             exu_valid,
    output logic             exu_ready,
    input  logic [RA_W-1:0]  exu_rd,
    input  logic             exu_wen,
    input  logic [XLEN-1:0]  exu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [RA_W-1:0]  lsu_rd,
    input  logic [2:0]       lsu_funct3,
    input  logic [1:0]       lsu_addr_lo,
    input  logic [XLEN-1:0]  lsu_rdata,
    output logic             w_en,
    output logic [RA_W-1:0]  waddr,
    output logic [XLEN-1:0]  wdata,
    output logic             misalign_err,
    output logic [CNT_W-1:0] instret
);

    logic                lsu_acc;
    logic                exu_acc;
    logic [XLEN-1:0]     ld_data;
    logic                ld_err;
    wb_res_t             res;
    logic                retire;
    logic                clr;

    logic                w_en_q, w_en_d;
    logic [RA_W-1:0]     waddr_q, waddr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    ysyx_23060096_load_align u_load_align (
        .funct3_i  (lsu_funct3),
        .addr_lo_i (lsu_addr_lo),
        .rdata_i   (lsu_rdata),
        .data_o    (ld_data),
        .err_o     (ld_err)
    );

    // Fixed priority: a load response always wins, the EXU waits.
    assign lsu_ready = ~rst;
    assign exu_ready = ~rst & ~lsu_valid;
    assign lsu_acc   = lsu_valid & lsu_ready;
    assign exu_acc   = exu_valid & exu_ready;

    always_comb begin
        res = '0;
        if (lsu_acc) begin
            res.valid = 1'b1;
            res.rd    = lsu_rd;
            res.data  = ld_data;
            res.wen   = ~ld_err;
            res.err   = ld_err;
        end else if (exu_acc) begin
            res.valid = 1'b1;
            res.rd    = exu_rd;
            res.data  = exu_data;
            res.wen   = exu_wen;
        end
    end

    // A dropped load still releases its destination; a no-write EXU op never owned one.
    assign retire = res.valid & ~res.err;
    assign clr    = res.valid & (res.wen | res.err);

    always_comb begin
        w_en_d    = res.valid & res.wen & (res.rd != '0);
        waddr_d   = w_en_d ? res.rd : waddr_q;
        wdata_d   = w_en_d ? res.data : wdata_q;
        err_d     = res.valid & res.err;
        instret_d = instret_q + CNT_W'(retire);
    end

    always_comb begin
        busy_d = busy_q;
        if (clr) begin
            busy_d[res.rd] = 1'b0;
        end
        // Set after clear so a newer writer of the same rd stays pending.
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
            busy_q    <= '0;
        end else begin
            w_en_q    <= w_en_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            instret_q <= instret_d;
            busy_q    <= busy_d;
        end
    end

    assign rs1_busy     = busy_q[rs1];
    assign rs2_busy     = busy_q[rs2];
    assign w_en         = w_en_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign misalign_err = err_q;
    assign instret      = instret_q;

endmodule
